buzzer_note_arbiter: RTL and testbench
======================================

// Module: buzzer_note_arbiter
// PURPOSE
// - Shares the single buzzer note bus between two requesters: live switch play (manual) and a
//   song/auto-play stream. Sits between the switch-to-note path and the buzzer tone generator.
// - Debounces the 10 switch lines, gives manual play priority (pre-empting auto), times
//   auto notes in ticks, and inserts a silent articulation gap between every ownership/note change.
// PARAMETERS
// - NOTE_W      10      note bus width (7 scale bits + 3 octave bits, passed through unmodified)
// - DUR_W       16      width of auto-note duration field (units of tick_en pulses)
// - DEB_CYCLES  1000000 clocks a switch vector must be stable before accepted (10 ms @100 MHz)
// - GAP_CYCLES  2000000 clocks of silence between notes (20 ms @100 MHz); must be >= 1
// PORTS
// - clk          in   1       system clock
// - rst_n        in   1       asynchronous active-low reset
// - sw_raw       in   NOTE_W  raw switch vector, asynchronous to clk
// - manual_en    in   1       1 = manual play allowed; 0 = switches ignored
// - tick_en      in   1       single-cycle duration tick (e.g. 1 ms strobe)
// - auto_valid   in   1       auto note offered
// - auto_note    in   NOTE_W  auto note, stable while auto_valid && !auto_ready
// - auto_dur     in   DUR_W   auto note length in ticks; 0 treated as 1
// - auto_ready   out  1       arbiter accepts auto note this cycle
// - auto_abort   out  1       1-cycle pulse: accepted auto note cut short by manual play
// - buzzer_note  out  NOTE_W  registered note to tone generator; 0 = silence
// - owner        out  2       00 none, 01 manual, 10 auto (11 unused)
// BEHAVIOUR
// - Reset (async assert, sync deassert via the rst_n domain): state IDLE, buzzer_note=0,
//   owner=00, auto_ready=0, auto_abort=0, debounce counter 0, debounced vector 0.
// - Debounce: sw_raw -> 2-flop sync -> counter; counter clears on any change of synced vector,
//   debounced vector (sw_db) updates when counter reaches DEB_CYCLES-1. manual_req = manual_en && sw_db!=0.
// - FSM states IDLE, MANUAL, AUTO, GAP; all outputs registered (1-cycle latency from decision).
//   IDLE:   manual_req -> MANUAL (priority); else auto_valid -> AUTO. buzzer_note=0.
//           auto_ready = !manual_req (combinational in IDLE only); handshake = auto_valid && auto_ready;
//           on handshake latch auto_note, load dur counter with max(auto_dur,1).
//   MANUAL: buzzer_note = sw_db each cycle (chord/octave change passes through with no gap);
//           owner=01. !manual_req -> GAP.
//   AUTO:   buzzer_note = latched note, owner=10. Counter decrements on tick_en; at count 1 with
//           tick_en -> GAP. manual_req -> GAP immediately, auto_abort pulses that cycle;
//           aborted note is dropped, never replayed. If both happen same cycle, abort wins.
//   GAP:    buzzer_note=0, owner=00, GAP_CYCLES clocks, then IDLE. Requests during GAP wait;
//           auto_ready stays 0. Manual release+repress inside GAP does not extend the gap.
// - Ownership never changes without passing through GAP (>= GAP_CYCLES silent clocks).
// - manual_en falling during MANUAL -> GAP next cycle. auto_valid dropping before handshake:
//   no effect (protocol violation tolerated, nothing latched).
// - Counters saturate/never wrap; dur counter width DUR_W, gap/debounce counters sized by $clog2.
// STRUCTURE
// - Shared package (buzzer_pkg): NOTE_W, owner encodings OWN_NONE/OWN_MAN/OWN_AUTO, FSM state
//   typedef, NOTE_SILENT = '0 (reused by tone generator and song player).
// - Sub-module switch_debounce (NOTE_W, DEB_CYCLES): sync + stability counter, outputs sw_db.
// - Top holds FSM, duration counter, gap counter, output registers.
// TESTING (bench params: DEB_CYCLES=4, GAP_CYCLES=3, tick_en every 2 clks)
// - Reset mid-AUTO (note 10'h004 playing): rst_n low -> same-cycle buzzer_note=0, owner=00, auto_ready=0.
// - Auto only: auto_note=10'h041, auto_dur=3 -> ready 1 cycle in IDLE, note on 3 ticks, then 3 zero clocks,
//   next note 10'h002 accepted 1 cycle after GAP; auto_dur=0 plays exactly 1 tick.
// - Debounce: sw_raw toggles 10'h001<->0 every 2 clks -> buzzer_note stays 0; held 10'h001 -> owner=01
//   after 2 sync + 4 stable + 1 reg clocks.
// - Pre-emption: auto 10'h010 playing, switches settle 10'h020 -> auto_abort 1 pulse, 3 silent clks,
//   then 10'h020, owner=01; aborted note never reappears.
// - Simultaneous: manual_req and auto_valid both in IDLE -> MANUAL, auto_ready=0; on release, GAP then
//   auto note accepted. manual_en=0 with switches 10'h3FF -> auto plays, owner never 01.
// - Manual chord change 10'h001 -> 10'h081 -> buzzer_note follows with no silent cycle.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer note path (arbiter, tone generator, song player).
// Contents: default note bus width, owner encodings, silent-note constant and the
// arbiter FSM state type.
package buzzer_pkg;

    // Note bus: 7 scale bits + 3 octave bits, carried through unmodified.
    localparam int unsigned NOTE_W  = 10;
    localparam int unsigned OWNER_W = 2;

    // Current owner of the buzzer note bus.
    localparam logic [OWNER_W-1:0] OWN_NONE = 2'b00;
    localparam logic [OWNER_W-1:0] OWN_MAN  = 2'b01;
    localparam logic [OWNER_W-1:0] OWN_AUTO = 2'b10;

    // An all-zero note means silence.
    localparam logic [NOTE_W-1:0] NOTE_SILENT = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_t;

endpackage : buzzer_pkg

// File: rtl/switch_debounce.sv
// Debounces a vector of mechanical switch lines.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   sw_raw      raw switch vector, asynchronous to clk
//   sw_db       debounced vector; updates once the synchronised vector has been
//               stable for DEB_CYCLES clocks
module switch_debounce #(
    parameter int unsigned NOTE_W     = 10,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NOTE_W-1:0] sw_raw,
    output logic [NOTE_W-1:0] sw_db
);

    localparam int unsigned       CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [NOTE_W-1:0] sync1;
    logic [NOTE_W-1:0] sync2;
    logic [CNT_W-1:0]  cnt;

    // Two-flop synchroniser plus stability counter. Comparing sync1 against sync2
    // spots a change of the synchronised vector one clock ahead, so the counter
    // restarts on the same edge that the new value lands in sync2. The counter
    // parks at CNT_LAST while the vector stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cnt   <= '0;
            sw_db <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            if (sync1 != sync2) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                sw_db <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : switch_debounce

// File: rtl/buzzer_note_arbiter.sv
// Shares the buzzer note bus between live switch play (manual, priority) and an
// auto-play note stream, with a silent articulation gap between every change of
// owner or auto note.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   sw_raw       raw switch vector (asynchronous)
//   manual_en    1 = switches may play
//   tick_en      one-cycle duration strobe for auto notes
//   auto_valid   auto note offered; auto_note / auto_dur its note and length in ticks
//   auto_ready   auto note accepted this cycle (IDLE only, combinational)
//   auto_abort   one-cycle pulse when an accepted auto note is cut by manual play
//   buzzer_note  registered note to the tone generator (0 = silence)
//   owner        00 none, 01 manual, 10 auto
module buzzer_note_arbiter
    import buzzer_pkg::*;
#(
    parameter int unsigned NOTE_W     = buzzer_pkg::NOTE_W,
    parameter int unsigned DUR_W      = 16,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES = 2000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NOTE_W-1:0] sw_raw,
    input  logic              manual_en,
    input  logic              tick_en,
    input  logic              auto_valid,
    input  logic [NOTE_W-1:0] auto_note,
    input  logic [DUR_W-1:0]  auto_dur,
    output logic              auto_ready,
    output logic              auto_abort,
    output logic [NOTE_W-1:0] buzzer_note,
    output logic [1:0]        owner
);

    localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [NOTE_W-1:0] SILENT  = NOTE_W'(NOTE_SILENT);

    logic [NOTE_W-1:0] sw_db;
    logic              manual_req;
    logic              ready_arm;
    logic              handshake;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [DUR_W-1:0]  dur_cnt;
    logic [DUR_W-1:0]  dur_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_nxt;
    logic [NOTE_W-1:0] note_latch;
    logic [NOTE_W-1:0] latch_nxt;
    logic [NOTE_W-1:0] note_nxt;
    logic [1:0]        owner_nxt;
    logic              abort_nxt;

    switch_debounce #(
        .NOTE_W     (NOTE_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_raw (sw_raw),
        .sw_db  (sw_db)
    );

    assign manual_req = manual_en && (sw_db != '0);

    // ready_arm holds auto_ready low while reset is asserted and for the first
    // clock after it is released.
    assign auto_ready = ready_arm && (state == ST_IDLE) && !manual_req;
    assign handshake  = auto_valid && auto_ready;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            dur_cnt     <= '0;
            gap_cnt     <= '0;
            note_latch  <= '0;
            ready_arm   <= 1'b0;
            buzzer_note <= '0;
            owner       <= OWN_NONE;
            auto_abort  <= 1'b0;
        end else begin
            state       <= state_nxt;
            dur_cnt     <= dur_nxt;
            gap_cnt     <= gap_nxt;
            note_latch  <= latch_nxt;
            ready_arm   <= 1'b1;
            buzzer_note <= note_nxt;
            owner       <= owner_nxt;
            auto_abort  <= abort_nxt;
        end
    end

    // Next state and next output values; outputs are silent / unowned unless a
    // state drives them.
    always_comb begin
        state_nxt = state;
        dur_nxt   = dur_cnt;
        gap_nxt   = '0;
        latch_nxt = note_latch;
        note_nxt  = SILENT;
        owner_nxt = OWN_NONE;
        abort_nxt = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (manual_req) begin
                    state_nxt = ST_MANUAL;
                    note_nxt  = sw_db;
                    owner_nxt = OWN_MAN;
                end else if (handshake) begin
                    state_nxt = ST_AUTO;
                    latch_nxt = auto_note;
                    dur_nxt   = (auto_dur == '0) ? DUR_W'(1) : auto_dur;
                    note_nxt  = auto_note;
                    owner_nxt = OWN_AUTO;
                end
            end

            ST_MANUAL: begin
                // Chord / octave changes pass straight through without a gap.
                if (!manual_req) begin
                    state_nxt = ST_GAP;
                end else begin
                    note_nxt  = sw_db;
                    owner_nxt = OWN_MAN;
                end
            end

            ST_AUTO: begin
                // Pre-emption is checked first so it wins over a same-cycle expiry.
                if (manual_req) begin
                    state_nxt = ST_GAP;
                    abort_nxt = 1'b1;
                end else if (tick_en && (dur_cnt <= DUR_W'(1))) begin
                    state_nxt = ST_GAP;
                end else begin
                    if (tick_en) begin
                        dur_nxt = dur_cnt - 1'b1;
                    end
                    note_nxt  = note_latch;
                    owner_nxt = OWN_AUTO;
                end
            end

            ST_GAP: begin
                // Requests wait here; the gap length is fixed regardless of input activity.
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : buzzer_note_arbiter

// File: tb/tb_buzzer_note_arbiter.sv
// Directed bench for buzzer_note_arbiter: auto-note table plus hand-written
// sequences for debounce, chord change, pre-emption, simultaneous requests and
// reset during playback.
module tb_buzzer_note_arbiter;

    localparam int unsigned NOTE_W = 10;
    localparam int unsigned DUR_W  = 16;
    localparam int unsigned DEB    = 4;
    localparam int unsigned GAP    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NOTE_W-1:0] sw_raw;
    logic              manual_en;
    logic              tick_en;
    logic              auto_valid;
    logic [NOTE_W-1:0] auto_note;
    logic [DUR_W-1:0]  auto_dur;
    logic              auto_ready;
    logic              auto_abort;
    logic [NOTE_W-1:0] buzzer_note;
    logic [1:0]        owner;

    int   n_cmp = 0;
    int   n_err = 0;
    logic tick_run = 1'b0;

    typedef struct {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
        int                ticks;
    } auto_vec_t;

    auto_vec_t vecs [5];

    always #5 clk = ~clk;

    buzzer_note_arbiter #(
        .NOTE_W     (NOTE_W),
        .DUR_W      (DUR_W),
        .DEB_CYCLES (DEB),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_raw      (sw_raw),
        .manual_en   (manual_en),
        .tick_en     (tick_en),
        .auto_valid  (auto_valid),
        .auto_note   (auto_note),
        .auto_dur    (auto_dur),
        .auto_ready  (auto_ready),
        .auto_abort  (auto_abort),
        .buzzer_note (buzzer_note),
        .owner       (owner)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge. tick_en
    // pulses on every other clock while tick_run is set.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick_en = tick_run ? ~tick_en : 1'b0;
    endtask

    // Count silent, not-ready clocks until the arbiter is back in IDLE.
    task automatic wait_gap(input string tag);
        int   n    = 0;
        logic loud = 1'b0;
        while (!auto_ready && n < 50) begin
            if (buzzer_note !== '0 || owner !== 2'b00) loud = 1'b1;
            n++;
            cyc();
        end
        chk({tag, "_gap_len"}, n, GAP);
        chk({tag, "_gap_silent"}, loud, 1'b0);
    endtask

    // Offer one auto note from IDLE, follow it to the end and through the gap.
    task automatic run_auto(input logic [NOTE_W-1:0] note, input logic [DUR_W-1:0] dur,
                            input int exp_ticks, input string tag);
        int   tk  = 0;
        int   n   = 0;
        logic bad = 1'b0;
        auto_note  = note;
        auto_dur   = dur;
        auto_valid = 1'b1;
        #1;
        chk({tag, "_ready"}, auto_ready, 1'b1);
        cyc();
        auto_valid = 1'b0;
        chk({tag, "_note"}, buzzer_note, note);
        chk({tag, "_owner"}, owner, 2'b10);
        chk({tag, "_ready_low"}, auto_ready, 1'b0);
        // Every tick the DUT sees while it still owns the bus counts toward the duration.
        while (owner == 2'b10 && n < 400) begin
            if (buzzer_note !== note) bad = 1'b1;
            if (tick_en) tk++;
            n++;
            cyc();
        end
        chk({tag, "_ticks"}, tk, exp_ticks);
        chk({tag, "_steady"}, bad, 1'b0);
        wait_gap(tag);
    endtask

    initial begin
        int   n;
        logic flag;

        vecs[0] = '{note: 10'h041, dur: 16'd3, ticks: 3};
        vecs[1] = '{note: 10'h002, dur: 16'd1, ticks: 1};
        vecs[2] = '{note: 10'h004, dur: 16'd0, ticks: 1};
        vecs[3] = '{note: 10'h3FF, dur: 16'd2, ticks: 2};
        vecs[4] = '{note: 10'h080, dur: 16'd5, ticks: 5};

        rst_n      = 1'b0;
        sw_raw     = '0;
        manual_en  = 1'b0;
        tick_en    = 1'b0;
        auto_valid = 1'b0;
        auto_note  = '0;
        auto_dur   = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_note", buzzer_note, 10'h000);
        chk("reset_owner", owner, 2'b00);
        chk("reset_ready", auto_ready, 1'b0);
        chk("reset_abort", auto_abort, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        cyc();
        tick_run = 1'b1;
        chk("post_reset_ready", auto_ready, 1'b1);

        // Auto-only table; consecutive entries are accepted on the first IDLE clock.
        for (int i = 0; i < 5; i++) begin
            run_auto(vecs[i].note, vecs[i].dur, vecs[i].ticks, $sformatf("auto%0d", i));
        end

        // Bouncing switches never reach the bus.
        manual_en = 1'b1;
        flag      = 1'b0;
        for (int i = 0; i < 28; i++) begin
            sw_raw = (i < 24 && ((i / 2) % 2 == 1)) ? 10'h001 : 10'h000;
            if (owner !== 2'b00 || buzzer_note !== '0) flag = 1'b1;
            cyc();
        end
        chk("deb_bounce_quiet", flag, 1'b0);

        // Held switch: 2 sync + 4 stable + 1 register clocks to ownership.
        sw_raw = 10'h001;
        repeat (6) cyc();
        chk("deb_early_owner", owner, 2'b00);
        cyc();
        chk("deb_owner", owner, 2'b01);
        chk("deb_note", buzzer_note, 10'h001);

        // Chord change follows without a silent clock.
        sw_raw = 10'h081;
        flag   = 1'b0;
        n      = 0;
        while (buzzer_note !== 10'h081 && n < 30) begin
            if (buzzer_note !== 10'h001 || owner !== 2'b01) flag = 1'b1;
            n++;
            cyc();
        end
        chk("chord_note", buzzer_note, 10'h081);
        chk("chord_owner", owner, 2'b01);
        chk("chord_no_gap", flag, 1'b0);

        // Release through the debouncer, then the gap.
        sw_raw = '0;
        n      = 0;
        while (owner == 2'b01 && n < 30) begin
            n++;
            cyc();
        end
        chk("rel_owner", owner, 2'b00);
        wait_gap("rel");

        // Pre-emption of a long auto note.
        auto_note  = 10'h010;
        auto_dur   = 16'd40;
        auto_valid = 1'b1;
        cyc();
        auto_valid = 1'b0;
        chk("pre_auto_owner", owner, 2'b10);
        sw_raw = 10'h020;
        n      = 0;
        while (!auto_abort && n < 40) begin
            n++;
            cyc();
        end
        chk("pre_abort", auto_abort, 1'b1);
        chk("pre_abort_silent", buzzer_note, 10'h000);
        cyc();
        chk("pre_abort_pulse", auto_abort, 1'b0);
        // Silent clocks counted from the abort clock: GAP clocks plus the IDLE decision clock.
        n = 1;
        while (buzzer_note === '0 && n < 40) begin
            n++;
            cyc();
        end
        chk("pre_silent_len", n, GAP + 1);
        chk("pre_note", buzzer_note, 10'h020);
        chk("pre_owner", owner, 2'b01);
        flag = 1'b0;
        repeat (8) begin
            if (buzzer_note === 10'h010) flag = 1'b1;
            cyc();
        end
        sw_raw = '0;
        n      = 0;
        while (owner == 2'b01 && n < 30) begin
            if (buzzer_note === 10'h010) flag = 1'b1;
            n++;
            cyc();
        end
        wait_gap("pre");
        repeat (10) begin
            if (buzzer_note === 10'h010 || owner !== 2'b00) flag = 1'b1;
            cyc();
        end
        chk("pre_no_replay", flag, 1'b0);

        // manual_en low: switches settle but never take the bus.
        manual_en = 1'b0;
        sw_raw    = 10'h3FF;
        flag      = 1'b0;
        repeat (10) begin
            if (owner !== 2'b00) flag = 1'b1;
            cyc();
        end
        chk("men_off_idle", flag, 1'b0);

        // Simultaneous manual and auto requests in IDLE: manual wins.
        manual_en  = 1'b1;
        auto_note  = 10'h155;
        auto_dur   = 16'd2;
        auto_valid = 1'b1;
        #1;
        chk("sim_ready", auto_ready, 1'b0);
        cyc();
        chk("sim_owner", owner, 2'b01);
        chk("sim_note", buzzer_note, 10'h3FF);
        repeat (3) cyc();
        chk("sim_hold_ready", auto_ready, 1'b0);
        manual_en = 1'b0;
        cyc();
        chk("men_fall_owner", owner, 2'b00);
        chk("men_fall_note", buzzer_note, 10'h000);
        wait_gap("sim");
        run_auto(10'h155, 16'd2, 2, "sim_auto");

        // With manual_en low the switched-on vector is ignored; auto plays.
        run_auto(10'h0AA, 16'd1, 1, "men_off_auto");
        flag = 1'b0;
        repeat (6) begin
            if (owner === 2'b01) flag = 1'b1;
            cyc();
        end
        chk("men_off_never_manual", flag, 1'b0);

        // Reset while an auto note is playing.
        sw_raw     = '0;
        auto_note  = 10'h004;
        auto_dur   = 16'd20;
        auto_valid = 1'b1;
        cyc();
        auto_valid = 1'b0;
        repeat (3) cyc();
        chk("rst_pre_owner", owner, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_note", buzzer_note, 10'h000);
        chk("rst_mid_owner", owner, 2'b00);
        chk("rst_mid_ready", auto_ready, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        cyc();
        chk("rst_recover_ready", auto_ready, 1'b1);
        chk("rst_recover_note", buzzer_note, 10'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_buzzer_note_arbiter
